// File: rtl/sprite_blitter_if.sv
// Command/plot bus between a sprite requester (master) and sprite_blitter (slave).
// The mirror signal exists only when SPRITE_BLITTER_MIRROR_EN is defined.
interface sprite_blitter_if #(
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 6,
  parameter int FRAME_W  = 1
);
  logic                start;
  logic [COORD_W-1:0]  origin_x;
  logic [COORD_W-1:0]  origin_y;
  logic [FRAME_W-1:0]  frame;
  logic                erase;
`ifdef SPRITE_BLITTER_MIRROR_EN
  logic                mirror;
`endif
  logic                busy;
  logic                done;
  logic                plot;
  logic [COORD_W-1:0]  out_x;
  logic [COORD_W-1:0]  out_y;
  logic [COLOUR_W-1:0] out_colour;

  modport master (
`ifdef SPRITE_BLITTER_MIRROR_EN
    output mirror,
`endif
    output start, origin_x, origin_y, frame, erase,
    input  busy, done, plot, out_x, out_y, out_colour
  );

  modport slave (
`ifdef SPRITE_BLITTER_MIRROR_EN
    input  mirror,
`endif
    input  start, origin_x, origin_y, frame, erase,
    output busy, done, plot, out_x, out_y, out_colour
  );
endinterface

// File: rtl/sprite_blitter.sv
// Sequential sprite renderer: scans a WxH bitmap one pixel per clock and emits clipped plot commands.
// Optional horizontal flip via the mirror input when SPRITE_BLITTER_MIRROR_EN is defined.
module sprite_blitter #(
  parameter int SPR_W    = 11,
  parameter int SPR_H    = 8,
  parameter int FRAMES   = 2,
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 6,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [FRAMES*SPR_W*SPR_H-1:0] SPRITE_MASK   = '1,
  parameter logic [COLOUR_W-1:0]           SPRITE_COLOUR = '1,
  parameter logic [COLOUR_W-1:0]           BG_COLOUR     = '0
) (
  input logic              clock,
  input logic              reset,
  sprite_blitter_if.slave  bus
);
  localparam int FRAME_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int COL_W     = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W     = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int MASK_BITS = FRAMES * SPR_W * SPR_H;
  localparam int IDX_W     = (MASK_BITS > 1) ? $clog2(MASK_BITS) : 1;
  localparam int CW1       = COORD_W + 1;
  localparam int PIX_PER_FRAME = SPR_W * SPR_H;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(SPR_H - 1);
  localparam logic [CW1-1:0]   SCR_W_LIM = CW1'(SCREEN_W);
  localparam logic [CW1-1:0]   SCR_H_LIM = CW1'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FINISH} state_t;

  state_t              r_state, w_next;
  logic [COL_W-1:0]    r_col, w_mask_col;
  logic [ROW_W-1:0]    r_row;
  logic [COORD_W-1:0]  r_ox, r_oy, r_x, r_y;
  logic [FRAME_W-1:0]  r_frame;
  logic                r_erase, w_mirror;
  logic                r_busy, r_done, r_plot;
  logic [COLOUR_W-1:0] r_colour;
  logic [IDX_W-1:0]    w_bit_idx;
  logic [CW1-1:0]      w_px, w_py;
  logic                w_hit, w_last_pos;

`ifdef SPRITE_BLITTER_MIRROR_EN
  logic r_mirror;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            r_mirror <= 1'b0;
    else if (r_state == S_IDLE && bus.start) r_mirror <= bus.mirror;
  end
  assign w_mirror = r_mirror;
`else
  assign w_mirror = 1'b0;
`endif

  assign w_last_pos = (r_col == COL_LAST) && (r_row == ROW_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_SCAN;
      S_SCAN:   if (w_last_pos) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Carry out of the COORD_W+1 sum marks a wrap past the coordinate range.
  always_comb begin
    w_mask_col = w_mirror ? (COL_LAST - r_col) : r_col;
    w_bit_idx  = IDX_W'(r_frame) * IDX_W'(PIX_PER_FRAME)
               + IDX_W'(r_row) * IDX_W'(SPR_W) + IDX_W'(w_mask_col);
    w_px       = {1'b0, r_ox} + CW1'(r_col);
    w_py       = {1'b0, r_oy} + CW1'(r_row);
    w_hit      = SPRITE_MASK[w_bit_idx]
               && !w_px[COORD_W] && (w_px < SCR_W_LIM)
               && !w_py[COORD_W] && (w_py < SCR_H_LIM);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col    <= '0;
      r_row    <= '0;
      r_ox     <= '0;
      r_oy     <= '0;
      r_frame  <= '0;
      r_erase  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else begin
      r_busy <= (w_next == S_SCAN);
      r_done <= (w_next == S_FINISH);
      r_plot <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_ox    <= bus.origin_x;
          r_oy    <= bus.origin_y;
          r_frame <= (int'(bus.frame) < FRAMES) ? bus.frame : '0;
          r_erase <= bus.erase;
          r_col   <= '0;
          r_row   <= '0;
        end
        S_SCAN: begin
          if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= w_last_pos ? '0 : r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
          if (w_hit) begin
            r_plot   <= 1'b1;
            r_x      <= w_px[COORD_W-1:0];
            r_y      <= w_py[COORD_W-1:0];
            r_colour <= r_erase ? BG_COLOUR : SPRITE_COLOUR;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.plot       = r_plot;
  assign bus.out_x      = r_x;
  assign bus.out_y      = r_y;
  assign bus.out_colour = r_colour;
endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a default-size instance and a 3x2 two-frame instance,
// checked against a row-major pixel-list model; mirror stimulus is added when SPRITE_BLITTER_MIRROR_EN is defined.
module tb_sprite_blitter;
  localparam int W0 = 11, H0 = 8, F0 = 2;
  localparam int W1 = 3,  H1 = 2, F1 = 2;
  localparam logic [F0*W0*H0-1:0] MASK0 = '1;
  localparam logic [F1*W1*H1-1:0] MASK1 = {6'b100000, 6'b000001};

  typedef struct {int x; int y; int c;} pix_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sprite_blitter_if #(.COORD_W(8), .COLOUR_W(6), .FRAME_W(1)) bus0 ();
  sprite_blitter_if #(.COORD_W(8), .COLOUR_W(6), .FRAME_W(1)) bus1 ();

  sprite_blitter #(.SPR_W(W0), .SPR_H(H0), .FRAMES(F0), .SPRITE_MASK(MASK0))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));
  sprite_blitter #(.SPR_W(W1), .SPR_H(H1), .FRAMES(F1), .SPRITE_MASK(MASK1))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  int checks = 0;
  int errors = 0;
  pix_t q0[$], q1[$];
  pix_t last0 = '{0, 0, 0};
  pix_t last1 = '{0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list every visible opaque pixel of the sprite in row-major order.
  task automatic predict(input int which, input int ox, input int oy, input int fr,
                         input int er, input int mi);
    int w, h, mc;
    logic [255:0] m;
    pix_t p;
    w = (which == 0) ? W0 : W1;
    h = (which == 0) ? H0 : H1;
    m = (which == 0) ? 256'(MASK0) : 256'(MASK1);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        mc = (mi != 0) ? (w - 1 - c) : c;
        if (m[fr*w*h + r*w + mc] && (ox + c < 160) && (oy + r < 120)) begin
          p = '{ox + c, oy + r, (er != 0) ? 0 : 63};
          if (which == 0) q0.push_back(p);
          else            q1.push_back(p);
        end
      end
    end
  endtask

  always @(negedge clock) begin
    pix_t p;
    if (bus0.plot === 1'b1) begin
      if (q0.size() == 0) check("unexpected_plot0", 32'(bus0.plot), 32'd0);
      else begin
        p = q0.pop_front();
        check("plot0_x", 32'(bus0.out_x), p.x);
        check("plot0_y", 32'(bus0.out_y), p.y);
        check("plot0_colour", 32'(bus0.out_colour), p.c);
        last0 = p;
      end
    end else begin
      check("hold0", {8'd0, bus0.out_x, bus0.out_y, 2'd0, bus0.out_colour},
            {8'd0, 8'(last0.x), 8'(last0.y), 2'd0, 6'(last0.c)});
    end
  end

  always @(negedge clock) begin
    pix_t p;
    if (bus1.plot === 1'b1) begin
      if (q1.size() == 0) check("unexpected_plot1", 32'(bus1.plot), 32'd0);
      else begin
        p = q1.pop_front();
        check("plot1_x", 32'(bus1.out_x), p.x);
        check("plot1_y", 32'(bus1.out_y), p.y);
        check("plot1_colour", 32'(bus1.out_colour), p.c);
        last1 = p;
      end
    end else begin
      check("hold1", {8'd0, bus1.out_x, bus1.out_y, 2'd0, bus1.out_colour},
            {8'd0, 8'(last1.x), 8'(last1.y), 2'd0, 6'(last1.c)});
    end
  end

  task automatic set_in(input int which, input bit st, input int ox, input int oy,
                        input int fr, input int er, input int mi);
    if (which == 0) begin
      bus0.start = st; bus0.origin_x = 8'(ox); bus0.origin_y = 8'(oy);
      bus0.frame = 1'(fr); bus0.erase = 1'(er);
`ifdef SPRITE_BLITTER_MIRROR_EN
      bus0.mirror = 1'(mi);
`endif
    end else begin
      bus1.start = st; bus1.origin_x = 8'(ox); bus1.origin_y = 8'(oy);
      bus1.frame = 1'(fr); bus1.erase = 1'(er);
`ifdef SPRITE_BLITTER_MIRROR_EN
      bus1.mirror = 1'(mi);
`endif
    end
  endtask

  task automatic set_noise(input int which, input bit st);
    set_in(which, st, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  function automatic logic get_busy(input int which);
    return (which == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic get_done(input int which);
    return (which == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic get_plot(input int which);
    return (which == 0) ? bus0.plot : bus1.plot;
  endfunction

  // Entered and left at 1 time unit after a rising edge, with both DUTs idle.
  task automatic run(input int which, input int ox, input int oy, input int fr, input int er,
                     input int mi, input int extra_at, input int rst_at, input bit start_at_finish);
    int npix, cyc, busy_cnt;
    bit got_done, aborted;
    npix = (which == 0) ? W0 * H0 : W1 * H1;
    set_in(which, 1'b1, ox, oy, fr, er, mi);
    predict(which, ox, oy, fr, er, mi);
    @(posedge clock); #1;
    set_noise(which, 1'b0);
    busy_cnt = 0; got_done = 0; aborted = 0;
    for (cyc = 1; cyc <= 300; cyc++) begin
      if (get_done(which) === 1'b1) begin got_done = 1; break; end
      if (get_busy(which) === 1'b1) busy_cnt++;
      if (rst_at != 0 && cyc == rst_at) begin aborted = 1; break; end
      set_noise(which, cyc == extra_at);
      @(posedge clock); #1;
    end
    if (aborted) begin
      reset = 1'b1;
      #1;
      check("rst_busy", 32'(get_busy(which)), 32'd0);
      check("rst_plot", 32'(get_plot(which)), 32'd0);
      check("rst_out_x", 32'((which == 0) ? bus0.out_x : bus1.out_x), 32'd0);
      q0.delete(); q1.delete();
      last0 = '{0, 0, 0}; last1 = '{0, 0, 0};
      set_noise(which, 1'b0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clock); #1;
        check("rst_no_done", 32'(get_done(which)), 32'd0);
        check("rst_idle_busy", 32'(get_busy(which)), 32'd0);
      end
      return;
    end
    check("done_seen", 32'(got_done), 32'd1);
    if (!got_done) return;
    check("done_latency", cyc, npix + 1);
    check("busy_cycles", busy_cnt, npix);
    set_noise(which, start_at_finish);
    @(posedge clock); #1;
    set_noise(which, 1'b0);
    check("done_single", 32'(get_done(which)), 32'd0);
    check("idle_busy", 32'(get_busy(which)), 32'd0);
    check("queue_drained", (which == 0) ? q0.size() : q1.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, mi;
    reset = 1'b1;
    set_in(0, 1'b0, 0, 0, 0, 0, 0);
    set_in(1, 1'b0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    check("reset_busy", 32'(bus0.busy), 32'd0);
    check("reset_done", 32'(bus0.done), 32'd0);
    check("reset_plot", 32'(bus0.plot), 32'd0);
    check("reset_outs", {8'd0, bus0.out_x, bus0.out_y, 2'd0, bus0.out_colour}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;

    run(0, 10, 20, 0, 0, 0, 0, 0, 1'b0);
    run(1, 5, 5, 0, 0, 0, 0, 0, 1'b0);
    run(1, 5, 5, 1, 0, 0, 0, 0, 1'b0);
    run(0, 0, 0, 0, 1, 0, 0, 0, 1'b0);
    run(0, 155, 115, 0, 0, 0, 0, 0, 1'b0);
    run(0, 250, 0, 0, 0, 0, 0, 0, 1'b0);
    run(0, 30, 40, 1, 0, 0, 40, 0, 1'b0);
    run(0, 12, 34, 0, 0, 0, 0, 30, 1'b0);
    run(0, 3, 7, 0, 0, 0, 0, 0, 1'b1);
    run(0, 100, 100, 0, 0, 0, 0, 0, 1'b0);
`ifdef SPRITE_BLITTER_MIRROR_EN
    run(1, 0, 0, 0, 0, 1, 0, 0, 1'b0);
    run(1, 0, 0, 0, 0, 0, 0, 0, 1'b0);
`endif

    for (int n = 0; n < 24; n++) begin
      w = $urandom_range(0, 1);
`ifdef SPRITE_BLITTER_MIRROR_EN
      mi = $urandom_range(0, 1);
`else
      mi = 0;
`endif
      run(w, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 165),
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 125),
          $urandom_range(0, 1), $urandom_range(0, 1), mi,
          ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 0, 0, $urandom_range(0, 1));
    end

    repeat (3) @(posedge clock);
    #1;
    check("final_queue0", q0.size(), 32'd0);
    check("final_queue1", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
